// File: rtl/tpu_gbuf_arbiter.sv
// Global-buffer arbiter: shares one single-port SRAM (1-cycle read latency)
// between the host loader/unloader and the TPU core buffer port.
//
// Handshake (both requesters): req/we/addr/wdata stay stable until gnt is
// seen high; the access completes in the gnt cycle. Holding req high issues
// back-to-back accesses. A granted read returns one cycle later, flagged by
// the requester's rvalid; rdata is a plain copy of mem_rdata for both sides.
//
// Arbitration:
//   t_busy=0 : round-robin. The requester that did not win last goes first.
//   t_busy=1 : TPU priority. After MAX_WAIT cycles of the host waiting, the
//              host is forced in for a single cycle.
module tpu_gbuf_arbiter #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int MAX_WAIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 t_busy,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [ADDR_BITS-1:0] h_addr,
  input  logic [DATA_BITS-1:0] h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic [DATA_BITS-1:0] h_rdata,
  input  logic                 t_req,
  input  logic                 t_we,
  input  logic [ADDR_BITS-1:0] t_addr,
  input  logic [DATA_BITS-1:0] t_wdata,
  output logic                 t_gnt,
  output logic                 t_rvalid,
  output logic [DATA_BITS-1:0] t_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // Registered arbitration state.
  logic       last_gnt;    // 0 = host won last, 1 = TPU won last
  logic [7:0] wait_cnt;    // host wait cycles under TPU priority
  logic       rd_owner_h;  // host read issued last cycle
  logic       rd_owner_t;  // TPU read issued last cycle

  logic h_gnt_c;
  logic t_gnt_c;
  logic host_escape;

  assign host_escape = (wait_cnt >= MAX_WAIT_C);

  // Grant decision: combinational from requests, mode and registered state.
  always_comb begin
    h_gnt_c = 1'b0;
    t_gnt_c = 1'b0;
    if (!rst) begin
      if (t_busy) begin
        if (t_req && !(h_req && host_escape)) begin
          t_gnt_c = 1'b1;
        end else if (h_req) begin
          h_gnt_c = 1'b1;
        end
      end else begin
        if (h_req && t_req) begin
          if (last_gnt) begin
            h_gnt_c = 1'b1;
          end else begin
            t_gnt_c = 1'b1;
          end
        end else if (h_req) begin
          h_gnt_c = 1'b1;
        end else if (t_req) begin
          t_gnt_c = 1'b1;
        end
      end
    end
  end

  assign h_gnt = h_gnt_c;
  assign t_gnt = t_gnt_c;

  // SRAM drive: mux the winner onto the port, park at zero when idle.
  always_comb begin
    mem_en    = h_gnt_c | t_gnt_c;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (t_gnt_c) begin
      mem_we    = t_we;
      mem_addr  = t_addr;
      mem_wdata = t_wdata;
    end else if (h_gnt_c) begin
      mem_we    = h_we;
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
    end
  end

  // Read data is shared; rvalid tells each side whether it owns this beat.
  // rvalid is also masked by rst so a pending return is dropped immediately.
  assign h_rdata  = mem_rdata;
  assign t_rdata  = mem_rdata;
  assign h_rvalid = rd_owner_h & ~rst;
  assign t_rvalid = rd_owner_t & ~rst;

  // Arbitration history, host wait counter and read-return ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= 1'b0;
      wait_cnt   <= 8'd0;
      rd_owner_h <= 1'b0;
      rd_owner_t <= 1'b0;
    end else begin
      if (h_gnt_c) begin
        last_gnt <= 1'b0;
      end else if (t_gnt_c) begin
        last_gnt <= 1'b1;
      end

      if (!t_busy || h_gnt_c) begin
        wait_cnt <= 8'd0;
      end else if (h_req && (wait_cnt != 8'hFF)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      rd_owner_h <= h_gnt_c & ~h_we;
      rd_owner_t <= t_gnt_c & ~t_we;
    end
  end

endmodule

// File: tb/tb_tpu_gbuf_arbiter.sv
// Self-checking bench for tpu_gbuf_arbiter. A behavioural SRAM sits on the
// memory port; a forked monitor scores read returns against a reference
// memory through per-requester expected queues and checks the memory bus
// every cycle. Scenario tasks check grant sequences inline.
module tb_tpu_gbuf_arbiter;

  localparam int ADDR_BITS = 16;
  localparam int DATA_BITS = 32;
  localparam int MAX_WAIT  = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 t_busy;
  logic                 h_req, h_we;
  logic [ADDR_BITS-1:0] h_addr;
  logic [DATA_BITS-1:0] h_wdata;
  logic                 h_gnt, h_rvalid;
  logic [DATA_BITS-1:0] h_rdata;
  logic                 t_req, t_we;
  logic [ADDR_BITS-1:0] t_addr;
  logic [DATA_BITS-1:0] t_wdata;
  logic                 t_gnt, t_rvalid;
  logic [DATA_BITS-1:0] t_rdata;
  logic                 mem_en, mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [DATA_BITS-1:0] h_exp_q[$];
  logic [DATA_BITS-1:0] t_exp_q[$];
  logic [DATA_BITS-1:0] sram    [0:255] = '{default: '0};
  logic [DATA_BITS-1:0] ref_mem [0:255] = '{default: '0};

  tpu_gbuf_arbiter #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .t_busy(t_busy),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_gnt(t_gnt), .t_rvalid(t_rvalid), .t_rdata(t_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural SRAM, 1-cycle read latency ----------------
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[7:0]];
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    t_req = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
  endtask

  task automatic drive_host(input logic req, input logic we,
                            input logic [ADDR_BITS-1:0] a,
                            input logic [DATA_BITS-1:0] d);
    h_req = req; h_we = we; h_addr = a; h_wdata = d;
  endtask

  task automatic drive_tpu(input logic req, input logic we,
                           input logic [ADDR_BITS-1:0] a,
                           input logic [DATA_BITS-1:0] d);
    t_req = req; t_we = we; t_addr = a; t_wdata = d;
  endtask

  // ---------------- scoreboard / bus monitor ----------------
  task automatic monitor();
    logic [DATA_BITS-1:0] e;
    logic [1+1+ADDR_BITS+DATA_BITS-1:0] exp_bus, act_bus;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if ({h_rvalid, t_rvalid} !== 2'b00) begin
          errors++;
          $display("FAIL rvalid_in_reset: got h=%b t=%b, want 0 0", h_rvalid, t_rvalid);
        end
        h_exp_q.delete();
        t_exp_q.delete();
      end else begin
        // read returns must arrive exactly one cycle after the read grant
        checks++;
        if (h_exp_q.size() > 0) begin
          e = h_exp_q.pop_front();
          if (h_rvalid !== 1'b1 || h_rdata !== e) begin
            errors++;
            $display("FAIL h_return: got rvalid=%b rdata=%h, want rvalid=1 rdata=%h", h_rvalid, h_rdata, e);
          end
        end else if (h_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL h_spurious_rvalid: got rvalid=%b, want 0", h_rvalid);
        end
        checks++;
        if (t_exp_q.size() > 0) begin
          e = t_exp_q.pop_front();
          if (t_rvalid !== 1'b1 || t_rdata !== e) begin
            errors++;
            $display("FAIL t_return: got rvalid=%b rdata=%h, want rvalid=1 rdata=%h", t_rvalid, t_rdata, e);
          end
        end else if (t_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL t_spurious_rvalid: got rvalid=%b, want 0", t_rvalid);
        end

        // grants must be exclusive and only for requesters that ask
        checks++;
        if ((h_gnt && t_gnt) || (h_gnt && !h_req) || (t_gnt && !t_req)) begin
          errors++;
          $display("FAIL gnt_legal: got h_gnt=%b t_gnt=%b with h_req=%b t_req=%b", h_gnt, t_gnt, h_req, t_req);
        end

        // memory bus follows the granted requester, zero when idle
        if (t_gnt)      exp_bus = {1'b1, t_we, t_addr, t_wdata};
        else if (h_gnt) exp_bus = {1'b1, h_we, h_addr, h_wdata};
        else            exp_bus = '0;
        act_bus = {mem_en, mem_we, mem_addr, mem_wdata};
        checks++;
        if (act_bus !== exp_bus) begin
          errors++;
          $display("FAIL mem_bus: got en=%b we=%b addr=%h wdata=%h, want en=%b we=%b addr=%h wdata=%h",
                   mem_en, mem_we, mem_addr, mem_wdata,
                   exp_bus[DATA_BITS+ADDR_BITS+1], exp_bus[DATA_BITS+ADDR_BITS],
                   exp_bus[DATA_BITS+ADDR_BITS-1:DATA_BITS], exp_bus[DATA_BITS-1:0]);
        end

        // expected results enter the queues when the access is accepted
        if (h_gnt) begin
          if (h_we) ref_mem[h_addr[7:0]] = h_wdata;
          else      h_exp_q.push_back(ref_mem[h_addr[7:0]]);
        end
        if (t_gnt) begin
          if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
          else      t_exp_q.push_back(ref_mem[t_addr[7:0]]);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; t_busy = 1'b0;
    drive_idle();
    drive_host(1'b1, 1'b1, 16'h0001, 32'h1);
    drive_tpu(1'b1, 1'b1, 16'h0002, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({h_gnt, t_gnt, h_rvalid, t_rvalid, mem_en, mem_we} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b rvalid=%b%b en=%b we=%b addr=%h wdata=%h, want all 0",
               h_gnt, t_gnt, h_rvalid, t_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (h_rdata !== mem_rdata || t_rdata !== mem_rdata) begin
      errors++;
      $display("FAIL reset_rdata: got h=%h t=%h, want %h", h_rdata, t_rdata, mem_rdata);
    end
    tick();
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_host_only();
    t_busy = 1'b0;
    drive_host(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (h_gnt !== 1'b1 || t_gnt !== 1'b0) begin
      errors++;
      $display("FAIL host_write_gnt: got h=%b t=%b, want h=1 t=0", h_gnt, t_gnt);
    end
    tick();
    drive_host(1'b1, 1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    checks++;
    if (h_gnt !== 1'b1 || t_gnt !== 1'b0) begin
      errors++;
      $display("FAIL host_read_gnt: got h=%b t=%b, want h=1 t=0", h_gnt, t_gnt);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (h_rvalid !== 1'b1 || h_rdata !== 32'hDEADBEEF || t_gnt !== 1'b0 || t_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL host_read_data: got rvalid=%b rdata=%h t_gnt=%b, want rvalid=1 rdata=deadbeef t_gnt=0",
               h_rvalid, h_rdata, t_gnt);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_t;
    t_busy = 1'b0;
    drive_host(1'b1, 1'b1, 16'h0100, 32'hAAAA0001);
    drive_tpu(1'b1, 1'b1, 16'h0200, 32'hBBBB0002);
    for (int i = 0; i < 6; i++) begin
      exp_t = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (t_gnt !== exp_t || h_gnt !== !exp_t ||
          mem_addr !== (exp_t ? 16'h0200 : 16'h0100)) begin
        errors++;
        $display("FAIL rr_cycle%0d: got t=%b h=%b addr=%h, want t=%b h=%b addr=%h",
                 i, t_gnt, h_gnt, mem_addr, exp_t, !exp_t, exp_t ? 16'h0200 : 16'h0100);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_starvation();
    logic exp_t;
    t_busy = 1'b1;
    drive_host(1'b1, 1'b1, 16'h0020, 32'h0000C0DE);
    drive_tpu(1'b1, 1'b1, 16'h0021, 32'h0000F00D);
    for (int i = 0; i < 2 * (MAX_WAIT + 1); i++) begin
      exp_t = ((i % (MAX_WAIT + 1)) != MAX_WAIT);
      @(negedge clk);
      checks++;
      if (t_gnt !== exp_t || h_gnt !== !exp_t) begin
        errors++;
        $display("FAIL starve_cycle%0d: got t=%b h=%b, want t=%b h=%b", i, t_gnt, h_gnt, exp_t, !exp_t);
      end
      tick();
    end
    drive_idle();
    t_busy = 1'b0;
  endtask

  task automatic test_read_ownership();
    t_busy = 1'b0;
    drive_tpu(1'b1, 1'b1, 16'h0004, 32'h11111111);
    tick();
    drive_idle();
    drive_host(1'b1, 1'b1, 16'h0008, 32'h22222222);
    tick();
    drive_idle();
    drive_tpu(1'b1, 1'b0, 16'h0004, 32'h0);
    @(negedge clk);
    checks++;
    if (t_gnt !== 1'b1) begin
      errors++;
      $display("FAIL own_t_read_gnt: got %b, want 1", t_gnt);
    end
    tick();
    drive_idle();
    drive_host(1'b1, 1'b0, 16'h0008, 32'h0);
    @(negedge clk);
    checks++;
    if (h_gnt !== 1'b1 || t_rvalid !== 1'b1 || t_rdata !== 32'h11111111 || h_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL own_t_return: got h_gnt=%b t_rvalid=%b t_rdata=%h h_rvalid=%b, want 1 1 11111111 0",
               h_gnt, t_rvalid, t_rdata, h_rvalid);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (h_rvalid !== 1'b1 || h_rdata !== 32'h22222222 || t_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL own_h_return: got h_rvalid=%b h_rdata=%h t_rvalid=%b, want 1 22222222 0",
               h_rvalid, h_rdata, t_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    t_busy = 1'b0;
    // rst in the cycle the TPU read would be granted
    rst = 1'b1;
    drive_tpu(1'b1, 1'b0, 16'h0004, 32'h0);
    @(negedge clk);
    checks++;
    if (t_gnt !== 1'b0 || h_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_gnt_blocked: got t=%b h=%b en=%b, want 0 0 0", t_gnt, h_gnt, mem_en);
    end
    tick();
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    checks++;
    if (t_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rvalid: got %b, want 0", t_rvalid);
    end
    // granted read whose return cycle is hit by rst
    tick();
    drive_tpu(1'b1, 1'b0, 16'h0004, 32'h0);
    @(negedge clk);
    checks++;
    if (t_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_gnt: got %b, want 1", t_gnt);
    end
    tick();
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++;
    if ({t_rvalid, h_rvalid, mem_en, mem_we} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL rst_drop_pending: got t_rvalid=%b h_rvalid=%b en=%b we=%b addr=%h, want all 0",
               t_rvalid, h_rvalid, mem_en, mem_we, mem_addr);
    end
    tick();
    rst = 1'b0;
    drive_tpu(1'b1, 1'b0, 16'h0004, 32'h0);
    @(negedge clk);
    checks++;
    if (t_gnt !== 1'b1 || t_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_resume_gnt: got t_gnt=%b t_rvalid=%b, want 1 0", t_gnt, t_rvalid);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (t_rvalid !== 1'b1 || t_rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL rst_resume_data: got rvalid=%b rdata=%h, want 1 11111111", t_rvalid, t_rdata);
    end
    tick();
  endtask

  task automatic test_mode_switch();
    logic exp_t;
    drive_host(1'b1, 1'b1, 16'h0030, 32'h30303030);
    drive_tpu(1'b1, 1'b1, 16'h0040, 32'h40404040);
    // part 1: host waits 5 cycles under priority, then RR picks the host
    t_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (t_gnt !== 1'b1 || h_gnt !== 1'b0) begin
        errors++;
        $display("FAIL mode_pri%0d: got t=%b h=%b, want t=1 h=0", i, t_gnt, h_gnt);
      end
      tick();
    end
    t_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (h_gnt !== 1'b1 || t_gnt !== 1'b0) begin
      errors++;
      $display("FAIL mode_rr_switch: got h=%b t=%b, want h=1 t=0", h_gnt, t_gnt);
    end
    tick();
    // part 2: wait_cnt must clear in the first idle-mode cycle, even with no host grant
    t_busy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    t_busy = 1'b0;
    h_req = 1'b0;
    @(negedge clk);
    checks++;
    if (t_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mode_t_only: got t=%b, want 1", t_gnt);
    end
    tick();
    t_busy = 1'b1;
    h_req = 1'b1;
    for (int i = 0; i < MAX_WAIT + 1; i++) begin
      exp_t = (i != MAX_WAIT);
      @(negedge clk);
      checks++;
      if (t_gnt !== exp_t || h_gnt !== !exp_t) begin
        errors++;
        $display("FAIL mode_wait_cleared%0d: got t=%b h=%b, want t=%b h=%b", i, t_gnt, h_gnt, exp_t, !exp_t);
      end
      tick();
    end
    drive_idle();
    t_busy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic hg, tg;
    drive_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hg = h_gnt;
      tg = t_gnt;
      tick();
      if (!h_req || hg)
        drive_host(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 31)), $urandom);
      if (!t_req || tg)
        drive_tpu(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 31)), $urandom);
      t_busy = 1'($urandom_range(0, 3) == 0);
    end
    drive_idle();
    t_busy = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    t_busy = 1'b0;
    drive_idle();
    fork
      monitor();
    join_none
    test_reset();
    test_host_only();
    test_round_robin();
    test_starvation();
    test_read_ownership();
    test_reset_mid_read();
    test_mode_switch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_gbuf_arbiter.md
Name: tpu_gbuf_arbiter

Overview:
- Shares one single-port global-buffer SRAM (1-cycle read latency) between two requesters: the host loader/unloader (firmware path) and the TPU core's buffer port.
- Round-robin arbitration while the TPU is idle.
- TPU-priority arbitration while the TPU is busy, with a bounded-starvation escape for the host.
- Instantiated once per global buffer (A, B, C) between the user-project bus logic and the TPU.

Parameters:
ADDR_BITS, 16, SRAM word address width
DATA_BITS, 32, SRAM data width (128 for buffer C)
MAX_WAIT, 8, host wait cycles under TPU priority before one forced host grant (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
t_busy  in  1  TPU busy; selects priority mode
h_req  in  1  host access request
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_BITS  host address
h_wdata  in  DATA_BITS  host write data
h_gnt  out  1  host access accepted this cycle
h_rvalid  out  1  host read data valid
h_rdata  out  DATA_BITS  host read data
t_req  in  1  TPU access request
t_we  in  1  TPU write / read
t_addr  in  ADDR_BITS  TPU address
t_wdata  in  DATA_BITS  TPU write data
t_gnt  out  1  TPU access accepted this cycle
t_rvalid  out  1  TPU read data valid
t_rdata  out  DATA_BITS  TPU read data
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_BITS  SRAM address
mem_wdata  out  DATA_BITS  SRAM write data
mem_rdata  in  DATA_BITS  SRAM read data, valid 1 cycle after a read enable

Behaviour:
- **Handshake:** req/we/addr/wdata held stable until gnt is sampled high. The transfer completes in the gnt cycle. A requester may keep req high to issue back-to-back accesses.
- **Grant path:** gnt is combinational from req, t_busy and registered state. Exactly one of h_gnt/t_gnt is high in a cycle, or neither.
- **Memory drive:** mem_en = h_gnt | t_gnt. mem_we/addr/wdata are muxed from the granted requester. When idle, mem_we=0 and mem_addr/mem_wdata hold 0.
- **Read return:** on a granted read, the matching rvalid pulses high exactly one cycle later. h_rdata = t_rdata = mem_rdata unconditionally; rvalid qualifies ownership. Write grants produce no rvalid.
- **Registered state:**
  - last_gnt: 0 = host, 1 = TPU; reset 0.
  - wait_cnt: 8 bits; reset 0.
  - rd_owner_h, rd_owner_t: rvalid flops; reset 0.
- **Mode RR (t_busy=0):**
  - Only one requester active: it wins.
  - Both active: the one not equal to last_gnt wins.
  - last_gnt updates on every grant.
  - wait_cnt is cleared.
- **Mode PRI (t_busy=1):**
  - TPU wins whenever t_req=1, except when wait_cnt >= MAX_WAIT and h_req=1: the host wins that one cycle.
  - Host wins whenever t_req=0.
  - wait_cnt increments (saturating at 255) each cycle h_req=1 and h_gnt=0.
  - wait_cnt clears on h_gnt.
- **t_busy toggling:** takes effect in the same cycle it changes (combinational into arbitration). wait_cnt clears in the first cycle t_busy is 0.
- **Simultaneous events:**
  - Grant plus outstanding read return in the same cycle is legal; pipelining gives full throughput of 1 access/cycle.
  - Host read and TPU read on consecutive cycles produce h_rvalid then t_rvalid on consecutive cycles.
- **Reset mid-operation:** all flops return to reset values on the next edge. Any pending rvalid is dropped (rvalid=0 the cycle after rst). gnt outputs are 0 while rst=1.
- **Outputs at reset:** h_gnt=0, t_gnt=0, h_rvalid=0, t_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. rdata follows mem_rdata.
- **Address range:** no range checking. Addresses pass through unmodified, so wrap is the SRAM's concern.

Test Plan:
1. **Host-only traffic:** t_busy=0; host writes 0xDEADBEEF@0x0010, then reads 0x0010 → h_gnt each cycle; h_rvalid one cycle after the read grant with h_rdata=0xDEADBEEF; t_gnt never asserted.
2. **Round-robin:** t_busy=0; both req held for 6 cycles, last_gnt=0 at start → grants alternate T,H,T,H,T,H; mem_addr alternates accordingly.
3. **Starvation escape:** t_busy=1, MAX_WAIT=8; t_req and h_req held continuously → 8 TPU grants, 1 host grant, repeating (period 9); wait_cnt back to 0 after each host grant.
4. **Read-return ownership:** back-to-back reads (TPU addr 0x0004 = 0x11111111, host addr 0x0008 = 0x22222222) → t_rvalid then h_rvalid on consecutive cycles, data matching; never both high.
5. **Reset mid-read:** assert rst in the cycle of a TPU read grant → t_rvalid=0 the next cycle; all outputs at reset values; normal operation resumes on the first cycle after rst deasserts.
6. **Mode switch:** t_busy 1→0 with wait_cnt=5 → next both-request cycle arbitrates by round-robin; wait_cnt=0.
